// File: rtl/npc_sim_pkg.sv
// npc_sim_pkg: shared constants and enums for the NPC simulation halt sequencer
package npc_sim_pkg;
   localparam logic [31:0] EBREAK_INST  = 32'h0010_0073;
   localparam logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF;
   typedef enum logic [1:0] {GOOD_TRAP, BAD_TRAP, TIMEOUT} halt_reason_e;
   typedef enum logic [1:0] {RUN, DRAIN, HALT} halt_state_e;
endpackage

// File: rtl/npc_halt_ctrl_if.sv
// npc_halt_ctrl_if: commit stream from the core and halt status back to the sim top
interface npc_halt_ctrl_if #(parameter int XLEN = 64, parameter int CNT_W = 64);
   logic              commit_valid;
   logic [31:0]       commit_inst;
   logic [XLEN-1:0]   commit_pc;
   logic [XLEN-1:0]   a0_value;
   logic              pipe_empty;
   logic              fetch_stop;
   logic              halted;
   logic [1:0]        halt_reason;
   logic [31:0]       halt_code;
   logic [XLEN-1:0]   halt_pc;
   logic [CNT_W-1:0]  inst_cnt;
   logic [CNT_W-1:0]  cycle_cnt;
   modport master (
      output commit_valid, commit_inst, commit_pc, a0_value, pipe_empty,
      input  fetch_stop, halted, halt_reason, halt_code, halt_pc, inst_cnt, cycle_cnt
   );
   modport slave (
      input  commit_valid, commit_inst, commit_pc, a0_value, pipe_empty,
      output fetch_stop, halted, halt_reason, halt_code, halt_pc, inst_cnt, cycle_cnt
   );
endinterface

// File: rtl/npc_watchdog.sv
// npc_watchdog: counts consecutive idle enabled cycles, pulses expire on the LIMIT-th one
module npc_watchdog #(parameter int LIMIT = 1024) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
   logic [W-1:0] cnt;
   assign expire = (LIMIT != 0) && enable && !clear && (cnt == W'(LIMIT - 1));
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/npc_halt_ctrl.sv
// npc_halt_ctrl: detects ebreak or idle timeout, drains the pipeline, then halts the simulation
module npc_halt_ctrl
   import npc_sim_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int CNT_W     = 64,
   parameter int WDT_LIMIT = 1024
) (
   input logic             clock,
   input logic             reset_n,
   npc_halt_ctrl_if.slave  bus
);
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_DRAIN = DRAIN;
   localparam logic [1:0] S_HALT  = HALT;
   logic [1:0]       state;
   logic [XLEN-1:0]  last_pc, pc_q;
   logic [31:0]      code_q;
   halt_reason_e     reason_q;
   logic [CNT_W-1:0] inst_q, cyc_q;
   logic             run, trap, expire;
   assign run  = state == S_RUN;
   assign trap = run && bus.commit_valid && bus.commit_inst == EBREAK_INST;
   npc_watchdog #(.LIMIT(WDT_LIMIT)) u_wdt (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (bus.commit_valid),
      .enable  (run),
      .expire  (expire)
   );
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state    <= S_RUN;
         last_pc  <= '0;
         pc_q     <= '0;
         code_q   <= '0;
         reason_q <= GOOD_TRAP;
         inst_q   <= '0;
         cyc_q    <= '0;
      end else begin
         if (state != S_HALT) cyc_q <= cyc_q + 1'b1;
         if (run && bus.commit_valid) begin
            inst_q  <= inst_q + 1'b1;
            last_pc <= bus.commit_pc;
         end
         if (trap) begin
            code_q   <= bus.a0_value[31:0];
            pc_q     <= bus.commit_pc;
            reason_q <= (bus.a0_value[31:0] == 32'd0) ? GOOD_TRAP : BAD_TRAP;
            state    <= S_DRAIN;
         end else if (expire) begin
            code_q   <= TIMEOUT_CODE;
            pc_q     <= last_pc;
            reason_q <= TIMEOUT;
            state    <= S_DRAIN;
         end else if (state == S_DRAIN && bus.pipe_empty) state <= S_HALT;
      end
   assign bus.fetch_stop  = state != S_RUN;
   assign bus.halted      = state == S_HALT;
   assign bus.halt_reason = reason_q;
   assign bus.halt_code   = code_q;
   assign bus.halt_pc     = pc_q;
   assign bus.inst_cnt    = inst_q;
   assign bus.cycle_cnt   = cyc_q;
endmodule

// File: tb/tb_npc_halt_ctrl.sv
// tb_npc_halt_ctrl: scoreboard bench for the halt sequencer (WDT_LIMIT=16 and 0 instances)
module tb_npc_halt_ctrl;
   import npc_sim_pkg::*;
   typedef struct {
      logic [1:0]  reason;
      logic [31:0] code;
      logic [63:0] pc;
      logic [63:0] inst;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   int          n_chk = 0;
   int          n_fail = 0;
   int          edges = 0;
   logic [63:0] n_inst = '0;
   exp_t        sbq[$];
   always #5 clk = ~clk;
   npc_halt_ctrl_if #(.XLEN(64), .CNT_W(64)) b16 ();
   npc_halt_ctrl_if #(.XLEN(64), .CNT_W(64)) b0 ();
   npc_halt_ctrl #(.XLEN(64), .CNT_W(64), .WDT_LIMIT(16)) u16 (.clock(clk), .reset_n(rst_n), .bus(b16));
   npc_halt_ctrl #(.XLEN(64), .CNT_W(64), .WDT_LIMIT(0))  u0  (.clock(clk), .reset_n(rst_n), .bus(b0));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      edges++;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      b16.commit_valid = 1'b0; b16.commit_inst = '0; b16.commit_pc = '0; b16.a0_value = '0; b16.pipe_empty = 1'b0;
      b0.commit_valid  = 1'b0; b0.commit_inst  = '0; b0.commit_pc  = '0; b0.a0_value  = '0; b0.pipe_empty  = 1'b0;
      #2;
      @(negedge clk);
      rst_n = 1'b1;
      edges = 0;
      n_inst = '0;
      sbq.delete();
   endtask
   task automatic commit(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] a0, input bit counted);
      b16.commit_valid = 1'b1;
      b16.commit_inst  = inst;
      b16.commit_pc    = pc;
      b16.a0_value     = a0;
      tick();
      b16.commit_valid = 1'b0;
      if (counted) n_inst++;
   endtask
   task automatic score();
      exp_t e;
      check("halted", b16.halted, 1);
      check("sb_pending", 64'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check("sb_reason", b16.halt_reason, e.reason);
         check("sb_code", b16.halt_code, e.code);
         check("sb_pc", b16.halt_pc, e.pc);
         check("sb_inst", b16.inst_cnt, e.inst);
      end
   endtask
   task automatic wait_halt(input int budget);
      for (int i = 0; i < budget && !b16.halted; i++) tick();
      score();
   endtask
   initial begin
      int ecyc;
      #1 rst_n = 1'b0;
      #2;
      check("rst_fetch_stop", b16.fetch_stop, 0);
      check("rst_halted", b16.halted, 0);
      check("rst_reason", b16.halt_reason, 0);
      check("rst_code", b16.halt_code, 0);
      check("rst_pc", b16.halt_pc, 0);
      check("rst_inst", b16.inst_cnt, 0);
      check("rst_cycle", b16.cycle_cnt, 0);
      // good trap with a 3-cycle drain
      do_reset();
      for (int i = 0; i < 5; i++) commit(32'h0000_0013, 64'h8000_0000 + 64'(4 * i), 64'd0, 1'b1);
      sbq.push_back('{2'd0, 32'd0, 64'h8000_0014, n_inst + 64'd1});
      commit(EBREAK_INST, 64'h8000_0014, 64'd0, 1'b1);
      check("t1_fetch_stop", b16.fetch_stop, 1);
      check("t1_not_halted", b16.halted, 0);
      tick();
      tick();
      check("t1_still_drain", b16.halted, 0);
      b16.pipe_empty = 1'b1;
      tick();
      score();
      check("t1_cycle", b16.cycle_cnt, 64'(edges));
      ecyc = edges;
      repeat (3) tick();
      check("t1_cycle_frozen", b16.cycle_cnt, 64'(ecyc));
      check("t1_sticky", b16.halted, 1);
      // bad trap, pipeline already empty
      do_reset();
      b16.pipe_empty = 1'b1;
      sbq.push_back('{2'd1, 32'd5, 64'h8000_0010, 64'd1});
      commit(EBREAK_INST, 64'h8000_0010, 64'h1234_0000_0000_0005, 1'b1);
      check("t2_min_drain", b16.halted, 0);
      wait_halt(4);
      // watchdog timeout after 16 idle cycles
      do_reset();
      b16.pipe_empty = 1'b1;
      commit(32'h0000_0013, 64'h8000_0020, 64'd3, 1'b1);
      repeat (15) tick();
      check("t3_no_timeout_yet", b16.fetch_stop, 0);
      tick();
      check("t3_timeout_stop", b16.fetch_stop, 1);
      sbq.push_back('{2'd2, 32'hFFFF_FFFF, 64'h8000_0020, 64'd1});
      wait_halt(4);
      // commits during drain are ignored
      do_reset();
      sbq.push_back('{2'd0, 32'd0, 64'h100, 64'd1});
      commit(EBREAK_INST, 64'h100, 64'd0, 1'b1);
      commit(32'h0000_0013, 64'h104, 64'd0, 1'b0);
      commit(EBREAK_INST, 64'h108, 64'd7, 1'b0);
      check("t4_inst_frozen", b16.inst_cnt, n_inst);
      check("t4_code_kept", b16.halt_code, 0);
      b16.pipe_empty = 1'b1;
      wait_halt(4);
      // async reset mid-drain
      do_reset();
      commit(32'h0000_0013, 64'h200, 64'd0, 1'b1);
      commit(32'h0000_0013, 64'h204, 64'd0, 1'b1);
      commit(EBREAK_INST, 64'h208, 64'd9, 1'b1);
      check("t5_in_drain", b16.fetch_stop, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_fetch_stop", b16.fetch_stop, 0);
      check("t5_halted", b16.halted, 0);
      check("t5_reason", b16.halt_reason, 0);
      check("t5_code", b16.halt_code, 0);
      check("t5_pc", b16.halt_pc, 0);
      check("t5_inst", b16.inst_cnt, 0);
      check("t5_cycle", b16.cycle_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      edges = 0;
      n_inst = '0;
      for (int i = 0; i < 3; i++) commit(32'h0000_0013, 64'h300 + 64'(4 * i), 64'd0, 1'b1);
      check("t5_inst_resume", b16.inst_cnt, n_inst);
      check("t5_cycle_resume", b16.cycle_cnt, 64'(edges));
      check("t5_run", b16.fetch_stop, 0);
      // watchdog disabled, unqualified ebreak word ignored
      do_reset();
      repeat (10000) tick();
      check("t6_no_halt", b0.halted, 0);
      check("t6_no_stop", b0.fetch_stop, 0);
      check("t6_cycle", b0.cycle_cnt, 64'(edges));
      b0.commit_inst = EBREAK_INST;
      b0.pipe_empty = 1'b1;
      repeat (5) tick();
      check("t6_invalid_ebreak", b0.halted, 0);
      check("t6_inst_zero", b0.inst_cnt, 0);
      b0.commit_valid = 1'b1;
      tick();
      b0.commit_valid = 1'b0;
      tick();
      check("t6_valid_ebreak", b0.halted, 1);
      check("t6_inst_one", b0.inst_cnt, 1);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
